ccff_stream_loader: RTL and testbench
=====================================

CCFF_STREAM_LOADER -- requirements
Module: ccff_stream_loader

Interface
REQ-001 Parameter CHAIN_LEN, 16: number of configuration flops in the downstream ccff chain (four 4-bit mux memories).
REQ-002 Parameter WORD_W, 8: width of host load and readback words.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high; ports prog_clk and pReset.
REQ-004 prog_clk  in  1  programming clock; all state updates on its rising edge.
REQ-005 pReset  in  1  synchronous active-high reset.
REQ-006 start  in  1  single-cycle pulse; begins a load pass when idle.
REQ-007 wr_data  in  WORD_W  host configuration word; MSB is shifted first.
REQ-008 wr_valid  in  1  wr_data is valid.
REQ-009 wr_ready  out  1  loader accepts wr_data this cycle.
REQ-010 rb_data  out  WORD_W  word of previous chain contents captured from ccff_tail.
REQ-011 rb_valid  out  1  rb_data is valid.
REQ-012 rb_ready  in  1  host accepts rb_data.
REQ-013 ccff_head  out  1  serial bit into the chain.
REQ-014 ccff_clk_en  out  1  enable for the external clock gate; chain shifts exactly once per cycle this is high.
REQ-015 ccff_tail  in  1  serial bit out of the last chain flop.
REQ-016 busy  out  1  pass in progress.
REQ-017 done  out  1  single-cycle pulse when the pass completes.

Function
REQ-018 The state machine SHALL have three states: IDLE, SHIFT and FLUSH.
- IDLE -> SHIFT on start.
- SHIFT -> FLUSH after shift number CHAIN_LEN.
- FLUSH -> IDLE once the final readback word is accepted. done is pulsed on that transition.
REQ-019 start in SHIFT or FLUSH SHALL be ignored. wr_valid outside SHIFT SHALL be ignored and wr_ready SHALL be 0 there.
REQ-020 In SHIFT, wr_ready SHALL be 1 only when the internal shift buffer is empty and bits of the pass remain.
- A word is accepted when wr_valid and wr_ready are both 1.
REQ-021 A shift cycle SHALL occur when all three hold:
- the shift buffer holds a bit;
- the readback packer is not holding an unaccepted full word;
- the bit count is below CHAIN_LEN.
On a shift cycle, ccff_clk_en=1, ccff_head=current buffer MSB, and ccff_tail is sampled into the packer in that same cycle.
REQ-022 Off shift cycles, ccff_clk_en SHALL be 0 and ccff_head SHALL hold its last value.
- Chain flops never shift without ccff_clk_en, so a stall preserves alignment.
REQ-023 The bit counter SHALL be ceil(log2(CHAIN_LEN+1)) bits wide and increment only on shift cycles.
- It wraps to 0 on entry to IDLE.
REQ-024 If CHAIN_LEN is not a multiple of WORD_W, only the top CHAIN_LEN mod WORD_W bits of the last accepted word SHALL be shifted; the rest are discarded.
REQ-025 The packer SHALL fill rb_data MSB-first, one bit per shift.
- It presents rb_valid=1 when WORD_W bits are collected, or at the last bit of the pass with zero-padded LSBs.
- rb_data and rb_valid are held until rb_ready.
REQ-026 A word acceptance and the shifting of that buffer's final bit MAY occur in the same cycle, giving back-to-back shifts.
- Throughput is one bit per cycle with wr_valid and rb_ready held high.
REQ-027 busy SHALL be 1 in SHIFT and FLUSH and 0 in IDLE.

Reset
REQ-028 Reset values:
- state=IDLE; counter=0; buffers empty.
- wr_ready=0, rb_valid=0, rb_data=0.
- ccff_head=0, ccff_clk_en=0.
- busy=0, done=0.
REQ-029 pReset asserted mid-pass SHALL abort it next edge with no done pulse.
- The chain contents are then undefined and a fresh start is required.

Structure
REQ-030 Package ccff_loader_pkg SHALL hold the state enum and the default CHAIN_LEN/WORD_W constants.
REQ-031 The readback deserializer SHALL be a separate sub-module, ccff_rb_packer.

Verification
REQ-032 Bench with CHAIN_LEN=16, WORD_W=8 and a behavioural 16-flop chain model preloaded with 0x1234:
- load 0xA5, 0x3C with wr_valid and rb_ready held high;
- -> 16 contiguous ccff_clk_en cycles;
- -> chain reads 0xA53C;
- -> rb words 0x12, 0x34;
- -> done pulses one cycle after the rb word 0x34 is accepted.
REQ-033 rb_ready held low for 5 cycles after the first rb word:
- -> ccff_clk_en stays 0 during the stall;
- -> final chain and readback values are still exact.
REQ-034 wr_valid gapped 3 cycles between the two words -> the shift pauses and the result is identical to REQ-032.
REQ-035 start pulsed again during SHIFT, and wr_valid driven in IDLE -> no effect, and wr_ready stays 0 in IDLE.
REQ-036 pReset after 7 shifts:
- -> next cycle all outputs match REQ-028 and no done pulse occurs;
- -> a subsequent full pass succeeds.
REQ-037 CHAIN_LEN=12 build, load 0xF0 then 0xAB:
- -> 12 shifts; chain receives 0xF0A;
- -> the last rb word has 4 zero LSBs.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and default geometry for the ccff stream loader.
package ccff_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam int DEF_CHAIN_LEN = 16;
   localparam int DEF_WORD_W    = 8;

endpackage

// File: rtl/ccff_rb_packer.sv
// Deserializes bits leaving the chain tail into MSB-first readback words.
module ccff_rb_packer
   import ccff_loader_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              bit_valid,
   input  logic              bit_in,
   input  logic              bit_last,
   input  logic              rb_ready,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid,
   output logic              stall
);

   localparam int CW = $clog2(WORD_W + 1);

   logic [WORD_W-1:0] acc_q;
   logic [WORD_W-1:0] acc_next;
   logic [CW-1:0]     cnt_q;
   logic              word_done;

   // A word being accepted this cycle frees the packer for the incoming bit.
   assign stall = rb_valid & ~rb_ready;

   always_comb begin
      acc_next = acc_q;
      for (int i = 0; i < WORD_W; i++) begin
         if (int'(cnt_q) == WORD_W - 1 - i) acc_next[i] = bit_in;
      end
      word_done = bit_valid && ((int'(cnt_q) == WORD_W - 1) || bit_last);
   end

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         acc_q    <= '0;
         cnt_q    <= '0;
         rb_data  <= '0;
         rb_valid <= 1'b0;
      end else begin
         if (rb_valid && rb_ready) rb_valid <= 1'b0;
         if (bit_valid) begin
            if (word_done) begin
               rb_data  <= acc_next;
               rb_valid <= 1'b1;
               acc_q    <= '0;
               cnt_q    <= '0;
            end else begin
               acc_q <= acc_next;
               cnt_q <= cnt_q + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/ccff_stream_loader.sv
// Streams host words into a ccff chain while reading back its previous contents.
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_SHIFT | accepting words and shifting the chain
//   ST_FLUSH | waiting for the host to take the final readback word
module ccff_stream_loader
   import ccff_loader_pkg::*;
#(
   parameter int CHAIN_LEN = DEF_CHAIN_LEN,
   parameter int WORD_W    = DEF_WORD_W
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid,
   input  logic              rb_ready,
   output logic              ccff_head,
   output logic              ccff_clk_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int BW    = $clog2(WORD_W + 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q;
   logic [CNT_W-1:0]  ld_cnt_q;
   logic [CNT_W-1:0]  ld_left;
   logic [WORD_W-1:0] buf_q;
   logic [BW-1:0]     buf_cnt_q;
   logic [BW-1:0]     ld_bits;
   logic              head_q;
   logic              done_q;
   logic              shift_en;
   logic              last_bit;
   logic              accept;
   logic              pk_stall;

   // A short final word only contributes the bits the chain still needs.
   assign ld_left = CNT_W'(CHAIN_LEN) - ld_cnt_q;
   assign ld_bits = (int'(ld_left) >= WORD_W) ? BW'(WORD_W) : BW'(ld_left);

   always_comb begin
      shift_en = (state_q == ST_SHIFT) && (buf_cnt_q != '0) && !pk_stall &&
                 (bit_cnt_q < CNT_W'(CHAIN_LEN));
      last_bit = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
      wr_ready = (state_q == ST_SHIFT) && (ld_cnt_q < CNT_W'(CHAIN_LEN)) &&
                 ((buf_cnt_q == '0) || ((buf_cnt_q == BW'(1)) && shift_en));
      accept   = wr_valid && wr_ready;

      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_SHIFT;
         ST_SHIFT: if (shift_en && last_bit) state_d = ST_FLUSH;
         ST_FLUSH: if (rb_valid && rb_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   assign ccff_clk_en = shift_en;
   assign ccff_head   = shift_en ? buf_q[WORD_W-1] : head_q;
   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         ld_cnt_q  <= '0;
         buf_q     <= '0;
         buf_cnt_q <= '0;
         head_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == ST_FLUSH) && (state_d == ST_IDLE);
         if (shift_en) head_q <= buf_q[WORD_W-1];
         if (state_d == ST_IDLE) begin
            bit_cnt_q <= '0;
            ld_cnt_q  <= '0;
            buf_cnt_q <= '0;
         end else begin
            if (shift_en) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            // A load overrides the shift of the buffer's last bit.
            if (accept) begin
               buf_q     <= wr_data;
               buf_cnt_q <= ld_bits;
               ld_cnt_q  <= ld_cnt_q + CNT_W'(ld_bits);
            end else if (shift_en) begin
               buf_q     <= {buf_q[WORD_W-2:0], 1'b0};
               buf_cnt_q <= buf_cnt_q - BW'(1);
            end
         end
      end
   end

   ccff_rb_packer #(.WORD_W(WORD_W)) u_packer (
      .prog_clk  (prog_clk),
      .pReset    (pReset),
      .bit_valid (shift_en),
      .bit_in    (ccff_tail),
      .bit_last  (last_bit),
      .rb_ready  (rb_ready),
      .rb_data   (rb_data),
      .rb_valid  (rb_valid),
      .stall     (pk_stall)
   );

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Bench for ccff_stream_loader: 16- and 12-flop chain builds with behavioural chain models.
module tb_ccff_stream_loader;

   logic prog_clk = 1'b0;
   logic pReset, start, wr_valid, rb_ready, sel;
   logic [7:0] wr_data;

   always #5 prog_clk = ~prog_clk;

   logic wr_ready16, rb_valid16, head16, en16, tail16, busy16, done16;
   logic wr_ready12, rb_valid12, head12, en12, tail12, busy12, done12;
   logic [7:0] rb_data16, rb_data12;
   logic start16, start12, wr_valid16, wr_valid12;

   logic [15:0] chain16;
   logic [11:0] chain12;
   logic        pre_req16 = 1'b0;
   logic        pre_req12 = 1'b0;
   logic [15:0] pre_val;

   assign start16    = start & ~sel;
   assign start12    = start & sel;
   assign wr_valid16 = wr_valid & ~sel;
   assign wr_valid12 = wr_valid & sel;

   always @(posedge prog_clk) begin
      if (pre_req16) chain16 <= pre_val;
      else if (en16) chain16 <= {chain16[14:0], head16};
   end
   always @(posedge prog_clk) begin
      if (pre_req12) chain12 <= pre_val[11:0];
      else if (en12) chain12 <= {chain12[10:0], head12};
   end
   assign tail16 = chain16[15];
   assign tail12 = chain12[11];

   ccff_stream_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
      .prog_clk(prog_clk), .pReset(pReset), .start(start16),
      .wr_data(wr_data), .wr_valid(wr_valid16), .wr_ready(wr_ready16),
      .rb_data(rb_data16), .rb_valid(rb_valid16), .rb_ready(rb_ready),
      .ccff_head(head16), .ccff_clk_en(en16), .ccff_tail(tail16),
      .busy(busy16), .done(done16)
   );

   ccff_stream_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut12 (
      .prog_clk(prog_clk), .pReset(pReset), .start(start12),
      .wr_data(wr_data), .wr_valid(wr_valid12), .wr_ready(wr_ready12),
      .rb_data(rb_data12), .rb_valid(rb_valid12), .rb_ready(rb_ready),
      .ccff_head(head12), .ccff_clk_en(en12), .ccff_tail(tail12),
      .busy(busy12), .done(done12)
   );

   logic       o_wr_ready, o_rb_valid, o_head, o_en, o_busy, o_done;
   logic [7:0] o_rb_data;
   assign o_wr_ready = sel ? wr_ready12 : wr_ready16;
   assign o_rb_valid = sel ? rb_valid12 : rb_valid16;
   assign o_rb_data  = sel ? rb_data12  : rb_data16;
   assign o_head     = sel ? head12     : head16;
   assign o_en       = sel ? en12       : en16;
   assign o_busy     = sel ? busy12     : busy16;
   assign o_done     = sel ? done12     : done16;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] exp_q[$];

   // Runs one pass on the selected build and checks it against the chain model.
   task automatic run_pass(input bit s, input logic [7:0] w0, input logic [7:0] w1,
                           input logic [15:0] pre, input int nbits, input int wr_gap,
                           input int rb_stall, input bit poke, input string tag);
      logic [15:0] prel, exp_chain, got_chain;
      logic [7:0]  words[2];
      logic [7:0]  exp_rb;
      int wi, gap_seen, stall_left, n_en, first_en, last_en, acc_cyc, done_cyc, en_stall;
      bit stalled, fin;
      words[0] = w0; words[1] = w1;
      wi = 0; gap_seen = 0; stall_left = 0; n_en = 0; first_en = -1; last_en = -1;
      acc_cyc = -1; done_cyc = -1; en_stall = 0; stalled = 0; fin = 0;
      prel      = pre << (16 - nbits);
      exp_chain = {w0, w1} >> (16 - nbits);
      exp_q.delete();
      exp_q.push_back(prel[15:8]);
      exp_q.push_back(prel[7:0]);

      @(negedge prog_clk);
      sel = s; pre_val = pre; start = 0; wr_valid = 0; rb_ready = 1;
      if (s) pre_req12 = 1; else pre_req16 = 1;
      @(negedge prog_clk);
      pre_req12 = 0; pre_req16 = 0;

      for (int cyc = 0; cyc < 120 && !fin; cyc++) begin
         start    = (cyc == 0) || (poke && cyc == 5);
         wr_valid = (wi < 2) && !(wi == 1 && gap_seen < wr_gap);
         wr_data  = words[(wi < 2) ? wi : 1];
         rb_ready = (stall_left == 0);
         #1;
         if (o_rb_valid && !stalled && rb_stall > 0) begin
            stalled = 1; stall_left = rb_stall; rb_ready = 0;
            #1;
         end
         if (cyc == 0) begin
            n_cmp++;
            if (o_wr_ready !== 1'b0 || o_busy !== 1'b0) begin
               n_bad++;
               $display("FAIL %s idle_outputs wr_ready=%b busy=%b want 0 0", tag, o_wr_ready, o_busy);
            end
         end
         if (cyc == 1) begin
            n_cmp++;
            if (o_busy !== 1'b1) begin
               n_bad++;
               $display("FAIL %s busy_in_pass got %b want 1", tag, o_busy);
            end
         end
         if (o_en) begin
            n_en++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
            if (!rb_ready) en_stall++;
         end
         if (wi == 1 && o_wr_ready && !wr_valid) gap_seen++;
         if (wr_valid && o_wr_ready) wi++;
         if (o_rb_valid && rb_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL %s rb_extra got %h want none", tag, o_rb_data);
            end else begin
               exp_rb = exp_q.pop_front();
               if (o_rb_data !== exp_rb) begin
                  n_bad++;
                  $display("FAIL %s rb_data got %h want %h", tag, o_rb_data, exp_rb);
               end
            end
            acc_cyc = cyc;
         end
         if (o_done) begin
            fin = 1; done_cyc = cyc;
            n_cmp++;
            if (o_busy !== 1'b0) begin
               n_bad++;
               $display("FAIL %s busy_at_done got %b want 0", tag, o_busy);
            end
         end
         if (stall_left > 0) stall_left--;
         @(negedge prog_clk);
      end
      start = 0; wr_valid = 0; rb_ready = 1;
      #1;

      n_cmp++;
      if (!fin) begin
         n_bad++;
         $display("FAIL %s done_timeout got no done want done within 120 cycles", tag);
      end else if (done_cyc !== acc_cyc + 1) begin
         n_bad++;
         $display("FAIL %s done_timing got cycle %0d want %0d", tag, done_cyc, acc_cyc + 1);
      end
      n_cmp++;
      if (n_en !== nbits) begin
         n_bad++;
         $display("FAIL %s shift_count got %0d want %0d", tag, n_en, nbits);
      end
      n_cmp++;
      if (last_en - first_en + 1 !== nbits + wr_gap + rb_stall) begin
         n_bad++;
         $display("FAIL %s shift_span got %0d want %0d", tag, last_en - first_en + 1,
                  nbits + wr_gap + rb_stall);
      end
      n_cmp++;
      if (en_stall !== 0) begin
         n_bad++;
         $display("FAIL %s shift_during_stall got %0d want 0", tag, en_stall);
      end
      got_chain = s ? {4'h0, chain12} : chain16;
      n_cmp++;
      if (got_chain !== exp_chain) begin
         n_bad++;
         $display("FAIL %s chain got %h want %h", tag, got_chain, exp_chain);
      end
      n_cmp++;
      if (exp_q.size() !== 0) begin
         n_bad++;
         $display("FAIL %s rb_missing got %0d left want 0", tag, exp_q.size());
      end
      n_cmp++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL %s after_done done=%b busy=%b want 0 0", tag, o_done, o_busy);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      logic [14:0] obs;
      for (int k = 0; k < 2; k++) begin
         sel = k[0];
         #1;
         obs = {o_wr_ready, o_rb_valid, o_rb_data, o_head, o_en, o_busy, o_done};
         n_cmp++;
         if (obs !== 15'h0) begin
            n_bad++;
            $display("FAIL %s reset_outputs dut%0d got %h want 0000", tag, k, obs);
         end
      end
      sel = 0;
   endtask

   task automatic test_reset();
      @(negedge prog_clk);
      pReset = 0;
      wr_valid = 1;
      check_reset_outputs("reset");
      wr_valid = 0;
   endtask

   task automatic test_idle_ignore(input string tag);
      int bad;
      bad = 0;
      sel = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge prog_clk);
         start = 0; wr_valid = 1; wr_data = 8'h5A;
         #1;
         if (o_wr_ready !== 1'b0 || o_busy !== 1'b0 || o_en !== 1'b0 || o_rb_valid !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_bad++;
         $display("FAIL %s idle_wr_valid bad_cycles=%0d want 0", tag, bad);
      end
      wr_valid = 0;
   endtask

   task automatic test_basic();
      run_pass(0, 8'hA5, 8'h3C, 16'h1234, 16, 0, 0, 0, "basic");
   endtask

   task automatic test_rb_stall();
      run_pass(0, 8'hA5, 8'h3C, 16'h1234, 16, 0, 5, 0, "rb_stall");
   endtask

   task automatic test_wr_gap();
      run_pass(0, 8'hA5, 8'h3C, 16'h1234, 16, 3, 0, 0, "wr_gap");
   endtask

   task automatic test_start_ignored();
      run_pass(0, 8'hA5, 8'h3C, 16'h1234, 16, 0, 0, 1, "start_ignored");
      test_idle_ignore("idle_after_pass");
   endtask

   task automatic test_abort();
      int n_en, n_done;
      bit reached;
      n_en = 0; n_done = 0; reached = 0;
      @(negedge prog_clk);
      sel = 0; pre_val = 16'h1234; pre_req16 = 1;
      @(negedge prog_clk);
      pre_req16 = 0;
      for (int cyc = 0; cyc < 40 && !reached; cyc++) begin
         start = (cyc == 0); wr_valid = 1; wr_data = 8'hA5; rb_ready = 1;
         #1;
         if (o_en) n_en++;
         if (o_done) n_done++;
         if (n_en == 7) reached = 1;
         @(negedge prog_clk);
      end
      n_cmp++;
      if (!reached) begin
         n_bad++;
         $display("FAIL abort_reach shifts got %0d want 7", n_en);
      end
      pReset = 1;
      @(negedge prog_clk);
      pReset = 0;
      check_reset_outputs("abort");
      for (int c = 0; c < 5; c++) begin
         #1;
         if (o_done) n_done++;
         @(negedge prog_clk);
      end
      wr_valid = 0;
      n_cmp++;
      if (n_done !== 0) begin
         n_bad++;
         $display("FAIL abort_done got %0d pulses want 0", n_done);
      end
      run_pass(0, 8'hA5, 8'h3C, 16'h1234, 16, 0, 0, 0, "after_abort");
   endtask

   task automatic test_chain12();
      run_pass(1, 8'hF0, 8'hAB, 16'h05A7, 12, 0, 0, 0, "chain12");
   endtask

   initial begin
      pReset = 1; start = 0; wr_valid = 0; rb_ready = 1; sel = 0; wr_data = 8'h00;
      pre_val = 16'h0;
      repeat (3) @(posedge prog_clk);
      test_reset();
      test_idle_ignore("idle");
      test_basic();
      test_rb_stall();
      test_wr_gap();
      test_start_ignored();
      test_abort();
      test_chain12();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
